carregador_matriz: RTL and testbench

- Upstream stage of the determinant units. Collects a serial byte stream of signed 8-bit elements and packs them row-major into the 200-bit matrix bus.
- Presents the packed bus together with the latched size, holding both stable until the consumer acknowledges.
- One instance per ULA, shared by the 2x2 through 5x5 determinant blocks.

---
 rtl/pkg_ula.sv | 43 ++++
 rtl/carregador_matriz.sv | 115 +++++++++++
 tb/tb_carregador_matriz.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkg_ula.sv
// Shared definitions for the matrix loader and the determinant units:
// element/bus geometry, loader state encoding and the legal matrix orders.
package pkg_ula;

    localparam int ELEM_W = 8;
    localparam int MAX_N  = 5;
    localparam int BUS_W  = MAX_N * MAX_N * ELEM_W;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } estado_t;

    localparam logic [7:0] TAM_2 = 8'd2;
    localparam logic [7:0] TAM_3 = 8'd3;
    localparam logic [7:0] TAM_4 = 8'd4;
    localparam logic [7:0] TAM_5 = 8'd5;

    // True when n is an order the determinant blocks can handle.
    function automatic logic tamanho_ok(input logic [7:0] n);
        return (n >= TAM_2) && (n <= TAM_5);
    endfunction

    // Index of the last element of an n x n matrix (n*n-1).
    function automatic logic [CNT_W-1:0] ultimo_indice(input logic [7:0] n);
        logic [CNT_W-1:0] r;
        case (n)
            TAM_2:   r = 5'd3;
            TAM_3:   r = 5'd8;
            TAM_4:   r = 5'd15;
            default: r = 5'd24;
        endcase
        return r;
    endfunction

    // Bit offset of element slot cnt inside the packed matrix bus.
    function automatic logic [7:0] offset_slot(input logic [CNT_W-1:0] cnt);
        return 8'(cnt) * 8'(ELEM_W);
    endfunction

endpackage

// File: rtl/carregador_matriz.sv
// Matrix loader: collects a serial stream of signed bytes, packs them
// row-major into the 200-bit matrix bus and holds the result stable until
// the consumer acknowledges it.
module carregador_matriz
    import pkg_ula::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inicio,
    input  logic [7:0]        tamanho_in,
    input  logic [7:0]        dado,
    input  logic              dado_valid,
    output logic              dado_ready,
    input  logic              ack,
    output logic [BUS_W-1:0]  matriz,
    output logic [7:0]        tamanho,
    output logic              matriz_valid,
    output logic              ocupado,
    output logic              erro
);

    estado_t                   estado;
    estado_t                   prox_estado;
    logic [CNT_W-1:0]          cnt;
    logic [7:0]                tam_lat;
    logic                      beat;
    logic                      ultimo;
    logic signed [ELEM_W-1:0]  elemento;

    // Bytes are stored verbatim; the signed view only documents the format.
    assign elemento = signed'(dado);
    assign beat     = (estado == LOAD) && dado_valid;
    assign ultimo   = (cnt == ultimo_indice(tam_lat));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= IDLE;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state and handshake outputs; all outputs are decoded from state so
    // an asynchronous reset clears them immediately.
    always_comb begin
        prox_estado  = estado;
        dado_ready   = 1'b0;
        ocupado      = 1'b0;
        matriz_valid = 1'b0;
        tamanho      = 8'd0;
        case (estado)
            IDLE: begin
                if (inicio && tamanho_ok(tamanho_in)) begin
                    prox_estado = LOAD;
                end
            end
            LOAD: begin
                dado_ready = 1'b1;
                ocupado    = 1'b1;
                if (beat && ultimo) begin
                    prox_estado = DONE;
                end
            end
            DONE: begin
                matriz_valid = 1'b1;
                tamanho      = tam_lat;
                // ack has priority over a simultaneous inicio, which is dropped.
                if (ack) begin
                    prox_estado = IDLE;
                end
            end
            default: begin
                prox_estado = IDLE;
            end
        endcase
    end

    // Size latch, error flag, element counter and slot writes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            matriz  <= '0;
            tam_lat <= 8'd0;
            cnt     <= '0;
            erro    <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (inicio) begin
                        if (tamanho_ok(tamanho_in)) begin
                            tam_lat <= tamanho_in;
                            matriz  <= '0;
                            cnt     <= '0;
                            erro    <= 1'b0;
                        end else begin
                            erro <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        matriz[offset_slot(cnt) +: ELEM_W] <= elemento;
                        // Counter parks on the last slot instead of wrapping.
                        if (!ultimo) begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_matriz.sv
// Bench for the matrix loader: table-driven vectors, directed multi-cycle
// sequences and a randomized run, all checked against a behavioural model.
module tb_carregador_matriz;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         inicio;
    logic [7:0]   tamanho_in;
    logic [7:0]   dado;
    logic         dado_valid;
    logic         dado_ready;
    logic         ack;
    logic [199:0] matriz;
    logic [7:0]   tamanho;
    logic         matriz_valid;
    logic         ocupado;
    logic         erro;

    int total = 0;
    int bad   = 0;

    // behavioural model: what the loader is doing and what it holds
    bit           m_carr;
    bit           m_pronto;
    bit           m_err;
    int           m_k;
    int           m_n;
    logic [199:0] m_mat;

    typedef struct {
        logic       ini;
        logic [7:0] tam;
        logic [7:0] d;
        logic       v;
        logic       a;
        logic       e_rdy;
        logic       e_vld;
        logic [7:0] e_tam;
        logic       e_err;
    } vec_t;

    vec_t tbl[12];

    always #5 clock = ~clock;

    carregador_matriz dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .inicio       (inicio),
        .tamanho_in   (tamanho_in),
        .dado         (dado),
        .dado_valid   (dado_valid),
        .dado_ready   (dado_ready),
        .ack          (ack),
        .matriz       (matriz),
        .tamanho      (tamanho),
        .matriz_valid (matriz_valid),
        .ocupado      (ocupado),
        .erro         (erro)
    );

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_carr   = 0;
        m_pronto = 0;
        m_err    = 0;
        m_k      = 0;
        m_n      = 0;
        m_mat    = '0;
    endtask

    // One clock of loader behaviour given the inputs currently driven.
    task automatic model_step();
        if (m_pronto) begin
            if (ack) m_pronto = 0;
        end else if (m_carr) begin
            if (dado_valid) begin
                m_mat[m_k*8 +: 8] = dado;
                m_k++;
                if (m_k == m_n * m_n) begin
                    m_carr   = 0;
                    m_pronto = 1;
                end
            end
        end else if (inicio) begin
            if (tamanho_in >= 2 && tamanho_in <= 5) begin
                m_n   = int'(tamanho_in);
                m_mat = '0;
                m_k   = 0;
                m_err = 0;
                m_carr = 1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic check_model();
        chk("dado_ready", 200'(dado_ready), 200'(m_carr));
        chk("ocupado", 200'(ocupado), 200'(m_carr));
        chk("matriz_valid", 200'(matriz_valid), 200'(m_pronto));
        chk("tamanho", 200'(tamanho), m_pronto ? 200'(m_n) : 200'd0);
        chk("erro", 200'(erro), 200'(m_err));
        chk("matriz", matriz, m_mat);
    endtask

    task automatic drive(input logic i, input logic [7:0] t, input logic [7:0] d,
                         input logic v, input logic a);
        inicio     = i;
        tamanho_in = t;
        dado       = d;
        dado_valid = v;
        ack        = a;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_model();
    endtask

    function automatic vec_t mk(input logic ini, input logic [7:0] tam, input logic [7:0] d,
                                input logic v, input logic a, input logic e_rdy,
                                input logic e_vld, input logic [7:0] e_tam, input logic e_err);
        vec_t r;
        r.ini = ini; r.tam = tam; r.d = d; r.v = v; r.a = a;
        r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_tam = e_tam; r.e_err = e_err;
        return r;
    endfunction

    initial begin
        logic [199:0] snap;
        int           k;
        int           cyc;

        // invalid sizes, then a 2x2 load with a stall, ignored inicio/ack, and release
        tbl[0]  = mk(1, 8'd1, 8'h00, 0, 0, 0, 0, 8'd0, 1);
        tbl[1]  = mk(1, 8'd6, 8'h00, 0, 0, 0, 0, 8'd0, 1);
        tbl[2]  = mk(0, 8'd0, 8'h05, 1, 0, 0, 0, 8'd0, 1);
        tbl[3]  = mk(1, 8'd2, 8'h00, 0, 0, 1, 0, 8'd0, 0);
        tbl[4]  = mk(0, 8'd0, 8'h11, 1, 0, 1, 0, 8'd0, 0);
        tbl[5]  = mk(0, 8'd0, 8'h99, 0, 0, 1, 0, 8'd0, 0);
        tbl[6]  = mk(0, 8'd0, 8'h22, 1, 0, 1, 0, 8'd0, 0);
        tbl[7]  = mk(1, 8'd9, 8'h33, 1, 1, 1, 0, 8'd0, 0);
        tbl[8]  = mk(0, 8'd0, 8'h44, 1, 0, 0, 1, 8'd2, 0);
        tbl[9]  = mk(1, 8'd3, 8'h00, 0, 0, 0, 1, 8'd2, 0);
        tbl[10] = mk(0, 8'd0, 8'h00, 0, 1, 0, 0, 8'd0, 0);
        tbl[11] = mk(0, 8'd0, 8'h00, 0, 1, 0, 0, 8'd0, 0);

        // reset state
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_matriz", matriz, 200'd0);
        chk("reset_flags", 200'({dado_ready, ocupado, matriz_valid, erro}), 200'd0);
        chk("reset_tamanho", 200'(tamanho), 200'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // table vectors
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].ini, tbl[i].tam, tbl[i].d, tbl[i].v, tbl[i].a);
            tick();
            chk($sformatf("tbl%0d_ready", i), 200'(dado_ready), 200'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), 200'(matriz_valid), 200'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_tam", i), 200'(tamanho), 200'(tbl[i].e_tam));
            chk($sformatf("tbl%0d_erro", i), 200'(erro), 200'(tbl[i].e_err));
        end
        chk("tbl_matriz_2x2", matriz, 200'h44332211);

        // 4x4 back-to-back load of 1..16
        drive(1, 8'd4, 0, 0, 0);
        tick();
        chk("4x4_ready_latency", 200'(dado_ready), 200'd1);
        for (int b = 1; b <= 16; b++) begin
            drive(0, 0, 8'(b), 1, 0);
            tick();
            chk($sformatf("4x4_valid_beat%0d", b), 200'(matriz_valid), 200'(b == 16));
        end
        chk("4x4_first", 200'(matriz[7:0]), 200'd1);
        chk("4x4_last", 200'(matriz[127:120]), 200'd16);
        chk("4x4_unused", 200'(matriz[199:128]), 200'd0);
        chk("4x4_tamanho", 200'(tamanho), 200'd4);
        chk("4x4_elem_1_2", 200'(matriz[(1*4+2)*8 +: 8]), 200'd7);
        drive(0, 0, 0, 0, 1);
        tick();

        // 5x5 with dado_valid toggling, values -1..-25
        drive(1, 8'd5, 0, 0, 0);
        tick();
        k = 0;
        cyc = 0;
        while (k < 25 && cyc < 100) begin
            if (cyc % 2 == 0) begin
                drive(0, 0, 8'hFF - 8'(k), 1, 0);
                k++;
            end else begin
                drive(0, 0, 8'h5A, 0, 0);
            end
            tick();
            if (k < 25) chk("5x5_ocupado", 200'(ocupado), 200'd1);
            cyc++;
        end
        chk("5x5_no_timeout", 200'(k), 200'd25);
        chk("5x5_valid", 200'(matriz_valid), 200'd1);
        chk("5x5_slot0", 200'(matriz[7:0]), 200'hFF);
        chk("5x5_slot24", 200'(matriz[199:192]), 200'hE7);
        chk("5x5_slot12", 200'(matriz[103:96]), 200'hF3);
        drive(0, 0, 0, 0, 1);
        tick();

        // 3x3 load, hold with ack low, then ack+inicio together
        drive(1, 8'd3, 0, 0, 0);
        tick();
        for (int b = 0; b < 9; b++) begin
            drive(0, 0, 8'($urandom), 1, 0);
            tick();
        end
        snap = matriz;
        for (int c = 0; c < 10; c++) begin
            drive(1'(c % 3 == 0), 8'd4, 8'($urandom), 1'(c % 2), 0);
            tick();
            chk("hold_matriz", matriz, snap);
            chk("hold_ready", 200'(dado_ready), 200'd0);
            chk("hold_valid", 200'(matriz_valid), 200'd1);
        end
        drive(1, 8'd4, 0, 0, 1);
        tick();
        chk("ackini_valid", 200'(matriz_valid), 200'd0);
        chk("ackini_ready", 200'(dado_ready), 200'd0);
        chk("ackini_kept", matriz, snap);
        drive(0, 0, 0, 1, 0);
        tick();
        chk("ackini_not_started", 200'(dado_ready), 200'd0);

        // asynchronous reset after 7 beats of a 4x4 load
        drive(1, 8'd4, 0, 0, 0);
        tick();
        for (int b = 0; b < 7; b++) begin
            drive(0, 0, 8'(b + 40), 1, 0);
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_matriz", matriz, 200'd0);
        chk("async_flags", 200'({dado_ready, ocupado, matriz_valid, erro}), 200'd0);
        chk("async_tamanho", 200'(tamanho), 200'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            drive(0, 0, 8'(c), 1, 0);
            tick();
            chk("after_reset_valid", 200'(matriz_valid), 200'd0);
        end

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            int r;
            logic [7:0] t;
            r = int'($urandom_range(0, 7));
            if (r < 5)       t = 8'(2 + r % 4);
            else if (r == 5) t = 8'd1;
            else if (r == 6) t = 8'd6;
            else             t = 8'($urandom);
            drive(1'($urandom_range(0, 5) == 0), t, 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
